multicycle_controller: RTL and testbench

- Sequences the existing MIPS datapath (instruction memory, register file, ALU, main memory) as a multi-cycle machine.
- Owns the PC and instruction register (IR).
- Issues per-state control strobes that replace the datapath's static control unit outputs.
- Sits between the top level and the datapath, so one instruction occupies several clock cycles instead of one combinational pass.

---
 rtl/mips_ctrl_pkg.sv | 36 +++
 rtl/opcode_classifier.sv | 29 ++
 rtl/multicycle_controller.sv | 163 ++++++++++++++++
 tb/tb_multicycle_controller.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, FSM states and ALU op encodings shared by the multicycle controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // One-hot instruction class; exactly one field is set for any opcode.
  typedef struct packed {
    logic rtype;
    logic addi;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic halt;
    logic other;
  } iclass_t;

endpackage

// File: rtl/opcode_classifier.sv
// rtl/opcode_classifier.sv - maps an opcode to a one-hot instruction class
module opcode_classifier
  import mips_ctrl_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic [5:0] opcode_i,
  output iclass_t    class_o
);

  // The halt match takes priority so HALT_OPCODE may alias any other opcode.
  always_comb begin
    class_o = '0;
    if (opcode_i == HALT_OPCODE) begin
      class_o.halt = 1'b1;
    end else begin
      case (opcode_i)
        OP_RTYPE: class_o.rtype = 1'b1;
        OP_ADDI:  class_o.addi  = 1'b1;
        OP_LW:    class_o.lw    = 1'b1;
        OP_SW:    class_o.sw    = 1'b1;
        OP_BEQ:   class_o.beq   = 1'b1;
        OP_J:     class_o.j     = 1'b1;
        default:  class_o.other = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle MIPS sequencer owning pc/ir; RETIRE_COUNT_EN adds a retire counter
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  input  logic        zero,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic        MemR,
  output logic        MemW,
  output logic        RegW,
  output logic        MemToReg,
  output logic        alusrc,
  output logic        regdest,
  output logic [1:0]  Aluout,
  output logic [2:0]  state,
  output logic        halted,
  output logic [31:0] retired_count
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        retire;
  iclass_t     cls;

  opcode_classifier #(.HALT_OPCODE(HALT_OPCODE)) u_classifier (
    .opcode_i (ir_q[31:26]),
    .class_o  (cls)
  );

  assign pc4    = pc_q + 32'(PC_STEP);
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes depend only on state_q and ir_q so the datapath sees stable controls per cycle.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    retire   = 1'b0;
    MemR     = 1'b0;
    MemW     = 1'b0;
    RegW     = 1'b0;
    MemToReg = 1'b0;
    alusrc   = 1'b0;
    regdest  = 1'b0;
    Aluout   = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (cls.halt) begin
          state_d = S_HALT;
        end else if (cls.j) begin
          pc_d    = {pc4[31:28], ir_q[25:0], 2'b00};
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (cls.other) begin
          pc_d    = pc4;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        Aluout  = cls.beq ? ALUOP_SUB : (cls.rtype ? ALUOP_FUNCT : ALUOP_ADD);
        alusrc  = cls.lw | cls.sw | cls.addi;
        regdest = cls.rtype;
        if (cls.beq) begin
          pc_d    = zero ? (pc4 + br_off) : pc4;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (cls.rtype || cls.addi) begin
          state_d = S_WB;
        end else if (cls.lw || cls.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        alusrc = 1'b1;
        Aluout = ALUOP_ADD;
        if (cls.sw) begin
          MemW    = 1'b1;
          pc_d    = pc4;
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (cls.lw) begin
          MemR    = 1'b1;
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        // ALU controls stay put so the write-back value is the same result computed in EXEC.
        RegW     = 1'b1;
        MemToReg = cls.lw;
        MemR     = cls.lw;
        regdest  = cls.rtype;
        alusrc   = cls.lw | cls.addi;
        Aluout   = cls.rtype ? ALUOP_FUNCT : ALUOP_ADD;
        pc_d     = pc4;
        state_d  = S_FETCH;
        retire   = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign pc     = pc_q;
  assign ir     = ir_q;
  assign state  = state_q;
  assign halted = (state_q == S_HALT);

`ifdef RETIRE_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
    end else if (retire) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign retired_count = 32'h0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed self-checking bench for multicycle_controller
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction;
  logic        zero;
  logic [31:0] pc, ir, retired_count;
  logic        MemR, MemW, RegW, MemToReg, alusrc, regdest, halted;
  logic [1:0]  Aluout;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  int ret_exp = 0;

  // {MemR, MemW, RegW, MemToReg, alusrc, regdest, Aluout}
  logic [7:0] sv;
  assign sv = {MemR, MemW, RegW, MemToReg, alusrc, regdest, Aluout};

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .zero          (zero),
    .pc            (pc),
    .ir            (ir),
    .MemR          (MemR),
    .MemW          (MemW),
    .RegW          (RegW),
    .MemToReg      (MemToReg),
    .alusrc        (alusrc),
    .regdest       (regdest),
    .Aluout        (Aluout),
    .state         (state),
    .halted        (halted),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ret(input string tag);
`ifdef RETIRE_COUNT_EN
    chk(tag, retired_count, ret_exp);
`else
    chk(tag, retired_count, 32'h0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    zero = 1'b0;
    instruction = 32'h0;
    tick();
    tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_strobes", 32'(sv), 32'h0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk_ret("rst_retired");
    rst = 1'b0;

    // R-type add at pc 0
    instruction = 32'h0022_1820;
    tick(); chk("rt_dec_state", 32'(state), 32'd1); chk("rt_ir", ir, 32'h0022_1820);
    chk("rt_dec_sv", 32'(sv), 32'h00);
    tick(); chk("rt_exec_state", 32'(state), 32'd2); chk("rt_exec_sv", 32'(sv), 32'h06);
    tick(); chk("rt_wb_state", 32'(state), 32'd4); chk("rt_wb_sv", 32'(sv), 32'h26);
    chk("rt_wb_pc", pc, 32'h0);
    tick(); chk("rt_done_state", 32'(state), 32'd0); chk("rt_pc", pc, 32'h4);
    chk("rt_done_sv", 32'(sv), 32'h00);
    ret_exp++;

    // lw at pc 4
    instruction = 32'h8C22_0008;
    tick(); chk("lw_dec_state", 32'(state), 32'd1);
    tick(); chk("lw_exec_sv", 32'(sv), 32'h08);
    tick(); chk("lw_mem_state", 32'(state), 32'd3); chk("lw_mem_sv", 32'(sv), 32'h88);
    tick(); chk("lw_wb_state", 32'(state), 32'd4); chk("lw_wb_sv", 32'(sv), 32'hB8);
    tick(); chk("lw_pc", pc, 32'h8); chk("lw_done_state", 32'(state), 32'd0);
    ret_exp++;

    // beq taken at pc 8: 8 + 4 + 12
    instruction = 32'h1000_0003;
    zero = 1'b1;
    tick(); chk("beq_t_dec", 32'(state), 32'd1);
    tick(); chk("beq_t_exec_sv", 32'(sv), 32'h01); chk("beq_t_exec_state", 32'(state), 32'd2);
    tick(); chk("beq_t_pc", pc, 32'h18); chk("beq_t_state", 32'(state), 32'd0);
    ret_exp++;
    chk_ret("retired_after_3");

    // beq not taken at 0x18
    zero = 1'b0;
    tick(); tick(); chk("beq_nt_exec_sv", 32'(sv), 32'h01);
    tick(); chk("beq_nt_pc", pc, 32'h1C);
    ret_exp++;

    // sw at 0x1C
    instruction = 32'hAC22_0008;
    tick(); chk("sw_dec_state", 32'(state), 32'd1);
    tick(); chk("sw_exec_sv", 32'(sv), 32'h08);
    tick(); chk("sw_mem_sv", 32'(sv), 32'h48); chk("sw_mem_state", 32'(state), 32'd3);
    tick(); chk("sw_after_sv", 32'(sv), 32'h00); chk("sw_pc", pc, 32'h20);
    ret_exp++;

    // j at 0x20 -> {pc4[31:28], 0x10, 00} = 0x40
    instruction = 32'h0800_0010;
    tick(); chk("j_dec_sv", 32'(sv), 32'h00);
    tick(); chk("j_pc", pc, 32'h40); chk("j_state", 32'(state), 32'd0);
    ret_exp++;

    // undefined opcode 010101 acts as NOP
    instruction = 32'h5400_0000;
    tick(); tick(); chk("nop_pc", pc, 32'h44); chk("nop_state", 32'(state), 32'd0);
    ret_exp++;

    // beq with offset -1 returns to itself: 0x48 - 4
    instruction = 32'h1000_FFFF;
    zero = 1'b1;
    tick(); tick(); tick(); chk("beq_neg_pc", pc, 32'h44);
    ret_exp++;

    // beq offset -19 from 0x44: 0x48 - 0x4C wraps to 0xFFFF_FFFC
    instruction = 32'h1000_FFED;
    tick(); tick(); tick(); chk("beq_wrap_pc", pc, 32'hFFFF_FFFC);
    ret_exp++;
    zero = 1'b0;
    instruction = 32'h5400_0000;
    tick(); tick(); chk("wrap_pc", pc, 32'h0);
    ret_exp++;
    chk_ret("retired_before_abort");

    // reset during EXEC aborts the R-type: no WB cycle, no RegW
    instruction = 32'h0022_1820;
    tick(); tick(); chk("abort_exec_state", 32'(state), 32'd2);
    rst = 1'b1;
    tick(); chk("abort_state", 32'(state), 32'd0); chk("abort_regw", 32'(RegW), 32'd0);
    chk("abort_pc", pc, 32'h0); chk("abort_ir", ir, 32'h0);
    ret_exp = 0;
    chk_ret("abort_retired");
    rst = 1'b0;

    // NOP to move off 0, then halt with pc and ir frozen
    instruction = 32'h5400_0000;
    tick(); tick(); chk("pre_halt_pc", pc, 32'h4);
    ret_exp++;
    instruction = 32'hFC00_0000;
    tick(); tick(); chk("halt_state", 32'(state), 32'd5); chk("halt_flag", 32'(halted), 32'd1);
    instruction = 32'h0022_1820;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_pc_frozen", pc, 32'h4);
      chk("halt_ir_frozen", ir, 32'hFC00_0000);
      chk("halt_sv", 32'(sv), 32'h00);
      chk("halt_hold", 32'(state), 32'd5);
    end
    chk_ret("halt_retired");
    rst = 1'b1;
    tick(); chk("halt_exit_state", 32'(state), 32'd0); chk("halt_exit_flag", 32'(halted), 32'd0);
    chk("halt_exit_pc", pc, 32'h0);
    rst = 1'b0;
    tick(); chk("post_rst_decode", 32'(state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
